// File: rtl/mem_arbiter.sv
// N-channel arbiter that serialises 1/2/4-byte loads and stores onto a byte-wide RAM port.
// Round-robin (MODE=0) or fixed lowest-index priority (MODE=1); IO-window stores stall on io_buffer_full.
module mem_arbiter #(
    parameter int N_CH = 2,
    parameter int MODE = 0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N_CH-1:0]     ch_valid,
    input  logic [32*N_CH-1:0]  ch_addr,
    input  logic [N_CH-1:0]     ch_wr,
    input  logic [2*N_CH-1:0]   ch_size,
    input  logic [32*N_CH-1:0]  ch_wdata,
    output logic [N_CH-1:0]     ch_done,
    output logic [31:0]         rdata_out,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [31:0]         mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_TAIL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_wr;
    logic [1:0]      r_last;
    logic [1:0]      r_beat;
    logic [31:0]     r_asm;
    logic [31:0]     r_mem_a;
    logic [7:0]      r_mem_dout;
    logic            r_wr_req;
    logic [N_CH-1:0] r_done;
    logic [31:0]     r_rdata;

    logic            w_gnt_any;
    logic [PW-1:0]   w_gnt_idx;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic            w_sel_wr;
    logic [1:0]      w_sel_size;
    logic [1:0]      w_sel_last;
    logic [N_CH-1:0] w_onehot;
    logic [31:0]     w_final;
    logic [1:0]      w_next_beat;
    logic [1:0]      w_prev_beat;
    logic            w_stall;

    // Round-robin: first pass scans from the pointer upward, second pass supplies the wrap-around.
    always_comb begin
        // NOTE: every comb output gets a default before any conditional path, so no latch is inferred.
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (!w_gnt_any && ch_valid[c] && (MODE != 0 || c >= int'(r_ptr))) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PW'(c);
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (!w_gnt_any && ch_valid[c]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PW'(c);
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wr    = 1'b0;
        w_sel_size  = '0;
        w_onehot    = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (c == int'(w_gnt_idx)) begin
                w_sel_addr  = ch_addr[32*c +: 32];
                w_sel_wdata = ch_wdata[32*c +: 32];
                w_sel_wr    = ch_wr[c];
                w_sel_size  = ch_size[2*c +: 2];
            end
            w_onehot[c] = (c == int'(r_gnt));
        end
    end

    // Size 3 is treated as a 4-byte access.
    assign w_sel_last  = (w_sel_size == 2'd0) ? 2'd0 :
                         (w_sel_size == 2'd1) ? 2'd1 : 2'd3;
    assign w_next_beat = r_beat + 2'd1;
    assign w_prev_beat = r_beat - 2'd1;
    assign w_stall     = r_wr_req && (r_mem_a[17:16] == 2'b11) && io_buffer_full;

    always_comb begin
        w_final = r_asm;
        w_final[{r_last, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_last     <= '0;
            r_beat     <= '0;
            r_asm      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_wr_req   <= 1'b0;
            r_done     <= '0;
            r_rdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values regardless of order.
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_gnt      <= w_gnt_idx;
                        if (MODE == 0) begin
                            r_ptr <= (w_gnt_idx == PW'(N_CH - 1)) ? '0 : w_gnt_idx + PW'(1);
                        end
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_wr       <= w_sel_wr;
                        r_last     <= w_sel_last;
                        r_beat     <= '0;
                        r_asm      <= '0;
                        r_mem_a    <= w_sel_addr;
                        r_mem_dout <= w_sel_wdata[7:0];
                        r_wr_req   <= w_sel_wr;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!w_stall) begin
                        // Byte b-1 arrives one cycle after its address was presented.
                        if (!r_wr && r_beat != 2'd0) begin
                            r_asm[{w_prev_beat, 3'b000} +: 8] <= mem_din;
                        end
                        if (r_beat == r_last) begin
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                            r_wr_req   <= 1'b0;
                            if (r_wr) begin
                                r_done  <= w_onehot;
                                r_rdata <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_TAIL;
                            end
                        end else begin
                            r_beat     <= w_next_beat;
                            r_mem_a    <= r_addr + {30'd0, w_next_beat};
                            r_mem_dout <= r_wdata[{w_next_beat, 3'b000} +: 8];
                        end
                    end
                end
                S_TAIL: begin
                    r_rdata <= w_final;
                    r_done  <= w_onehot;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_rdata <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ch_done   = r_done;
    assign rdata_out = r_rdata;
    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign mem_wr    = r_wr_req && !w_stall;

endmodule
